// File: rtl/im_loader_pkg.sv
// Shared constants and state encodings for the serial program loader.
// Used by both the UART receiver and the loader frame FSM.
package im_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_LEN,
        LD_DATA,
        LD_CSUM
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, glitch-rejecting start check.
// Latency: rx_valid pulses the cycle after the stop-bit sample (about 9.5 bit times after the start edge).
// No backpressure: rx_valid/rx_ferr are single-cycle pulses that the consumer must take when offered.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);
    import im_loader_pkg::*;

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

    logic            rx_s1;
    logic            rx_s2;
    logic            rx_d;
    rx_state_t       rx_state;
    logic [CW-1:0]   bit_timer;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_d      <= 1'b1;
            rx_state  <= RX_IDLE;
            bit_timer <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_ferr   <= 1'b0;
        end else begin
            rx_s1    <= uart_rxd;
            rx_s2    <= rx_s1;
            rx_d     <= rx_s2;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_d && !rx_s2) begin
                        rx_state  <= RX_START;
                        bit_timer <= '0;
                    end
                end
                RX_START: begin
                    // Line must still be low half a bit later, otherwise it was a glitch.
                    if (bit_timer == HALF_CNT) begin
                        bit_timer <= '0;
                        bit_idx   <= '0;
                        rx_state  <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (bit_timer == FULL_CNT) begin
                        bit_timer <= '0;
                        shift_reg <= {rx_s2, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (bit_timer == FULL_CNT) begin
                        bit_timer <= '0;
                        rx_state  <= RX_IDLE;
                        rx_valid  <= 1'b1;
                        rx_ferr   <= !rx_s2;
                        rx_data   <= shift_reg;
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/im_loader.sv
// Framed UART program loader writing instruction memory and holding the CPU in reset meanwhile.
// Latency: each write/flag update is registered one cycle after the receiver's rx_valid pulse.
// No backpressure: the memory write port accepts every im_we pulse; the UART cannot be stalled.
module im_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int IM_AW        = 7,
    parameter int TIMEOUT_CYC  = 10_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uart_rxd,
    output logic             im_we,
    output logic [IM_AW-1:0] im_waddr,
    output logic [31:0]      im_wdata,
    output logic             cpu_hold,
    output logic             load_done,
    output logic             load_err
);
    import im_loader_pkg::*;

    localparam int WCW     = IM_AW + 1;
    localparam int TW      = $clog2(TIMEOUT_CYC + 1);
    localparam int MAX_LEN = 1 << IM_AW;

    logic [7:0]     rx_data;
    logic           rx_valid;
    logic           rx_ferr;

    ld_state_t      state;
    logic [WCW-1:0] word_cnt;
    logic [WCW-1:0] len;
    logic [1:0]     byte_cnt;
    logic [7:0]     sum;
    logic [23:0]    asm_lo;
    logic [TW-1:0]  idle_cnt;
    logic           len_ok;
    logic           timed_out;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .uart_rxd (uart_rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr)
    );

    assign len_ok = (rx_data != 8'd0) && (int'(rx_data) <= MAX_LEN);

    // idle_cnt holds the number of cycles since the last byte, so the abort
    // lands exactly TIMEOUT_CYC cycles after that byte's rx_valid.
    assign timed_out = !rx_valid && (idle_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LD_IDLE;
            word_cnt  <= '0;
            len       <= '0;
            byte_cnt  <= '0;
            sum       <= '0;
            asm_lo    <= '0;
            idle_cnt  <= '0;
            im_we     <= 1'b0;
            im_waddr  <= '0;
            im_wdata  <= '0;
            cpu_hold  <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            im_we <= 1'b0;
            if (state != LD_IDLE) begin
                idle_cnt <= rx_valid ? TW'(1) : idle_cnt + 1'b1;
            end
            case (state)
                LD_IDLE: begin
                    if (rx_valid && !rx_ferr && rx_data == SYNC_BYTE) begin
                        state     <= LD_LEN;
                        cpu_hold  <= 1'b1;
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                        word_cnt  <= '0;
                        byte_cnt  <= '0;
                        sum       <= '0;
                        idle_cnt  <= TW'(1);
                    end
                end
                LD_LEN: begin
                    if (rx_valid) begin
                        if (rx_ferr || !len_ok) begin
                            load_err <= 1'b1;
                            state    <= LD_IDLE;
                        end else begin
                            len   <= WCW'(rx_data);
                            state <= LD_DATA;
                        end
                    end else if (timed_out) begin
                        load_err <= 1'b1;
                        state    <= LD_IDLE;
                    end
                end
                LD_DATA: begin
                    if (rx_valid) begin
                        if (rx_ferr) begin
                            load_err <= 1'b1;
                            state    <= LD_IDLE;
                        end else begin
                            sum      <= sum + rx_data;
                            byte_cnt <= byte_cnt + 1'b1;
                            case (byte_cnt)
                                2'd0: asm_lo[7:0]   <= rx_data;
                                2'd1: asm_lo[15:8]  <= rx_data;
                                2'd2: asm_lo[23:16] <= rx_data;
                                default: begin
                                    im_we    <= 1'b1;
                                    im_waddr <= word_cnt[IM_AW-1:0];
                                    im_wdata <= {rx_data, asm_lo};
                                    word_cnt <= word_cnt + 1'b1;
                                    if (word_cnt == len - 1'b1) begin
                                        state <= LD_CSUM;
                                    end
                                end
                            endcase
                        end
                    end else if (timed_out) begin
                        load_err <= 1'b1;
                        state    <= LD_IDLE;
                    end
                end
                LD_CSUM: begin
                    if (rx_valid) begin
                        state <= LD_IDLE;
                        if (!rx_ferr && rx_data == sum) begin
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end else if (timed_out) begin
                        load_err <= 1'b1;
                        state    <= LD_IDLE;
                    end
                end
                default: state <= LD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: UART byte driver, frame-level reference model, per-cycle compare.
module tb_im_loader;
    localparam int CPB = 16;
    localparam int AW  = 7;
    localparam int TMO = 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          uart_rxd = 1'b1;
    logic          im_we;
    logic [AW-1:0] im_waddr;
    logic [31:0]   im_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_err;

    always #5 clk = ~clk;

    im_loader #(
        .CLKS_PER_BIT (CPB),
        .IM_AW        (AW),
        .TIMEOUT_CYC  (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rxd  (uart_rxd),
        .im_we     (im_we),
        .im_waddr  (im_waddr),
        .im_wdata  (im_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rv_cnt   = 0;
    int last_rv  = 0;

    logic [7:0]    fr[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [31:0]   exp_data_q[$];
    int            obs_addr[$];
    logic [31:0]   obs_data[$];
    bit            exp_hold = 1'b0;
    bit            exp_done = 1'b0;
    bit            exp_err  = 1'b0;
    bit            flags_valid = 1'b0;
    bit            hold_after_sync = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: what a whole frame must do, from the frame rules alone.
    // bad = index of the byte sent with a zero stop bit (-1: none); a short frame means silence follows.
    task automatic model_frame(input int bad);
        int stop;
        int len;
        int nfull;
        logic [7:0] s;
        stop = (bad >= 0) ? bad : fr.size();
        exp_hold = 1'b1;
        exp_done = 1'b0;
        exp_err  = 1'b1;
        if (stop < 2) return;
        len = int'(fr[1]);
        if (len == 0 || len > (1 << AW)) return;
        nfull = (stop - 2) / 4;
        if (nfull > len) nfull = len;
        for (int w = 0; w < nfull; w++) begin
            exp_addr_q.push_back(AW'(w));
            exp_data_q.push_back({fr[2+4*w+3], fr[2+4*w+2], fr[2+4*w+1], fr[2+4*w]});
        end
        if (stop < 3 + 4 * len) return;
        s = 8'd0;
        for (int i = 0; i < 4 * len; i++) s = s + fr[2+i];
        if (fr[2+4*len] == s) begin
            exp_done = 1'b1;
            exp_err  = 1'b0;
            exp_hold = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = good_stop;
        repeat (CPB) @(negedge clk);
        uart_rxd = 1'b1;
        if (!good_stop) repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input int bad);
        for (int i = 0; i < fr.size(); i++) begin
            send_byte(fr[i], i != bad);
            if (i == 0) hold_after_sync = cpu_hold;
            if (i == bad) break;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic run_frame(input int bad);
        flags_valid = 1'b0;
        obs_addr.delete();
        obs_data.delete();
        model_frame(bad);
        send_frame(bad);
        flags_valid = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic good_frame(input int len, input logic [31:0] seed);
        logic [31:0] w;
        logic [7:0]  s;
        fr.delete();
        fr.push_back(8'hA5);
        fr.push_back(8'(len));
        s = 8'd0;
        for (int i = 0; i < len; i++) begin
            w = seed ^ (32'h01030507 * i);
            for (int k = 0; k < 4; k++) begin
                fr.push_back(w[8*k +: 8]);
                s = s + w[8*k +: 8];
            end
        end
        fr.push_back(s);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: every write against the model queue, flags against the model every settled cycle.
    always @(negedge clk) begin
        if (dut.rx_valid) begin
            rv_cnt++;
            last_rv = cyc;
        end
        if (!rst && im_we) begin
            obs_addr.push_back(int'(im_waddr));
            obs_data.push_back(im_wdata);
            chk("write_expected", 32'(exp_addr_q.size() != 0), 32'd1);
            if (exp_addr_q.size() != 0) begin
                chk("im_waddr", 32'(im_waddr), 32'(exp_addr_q.pop_front()));
                chk("im_wdata", im_wdata, exp_data_q.pop_front());
            end
        end
        if (flags_valid && !rst) begin
            chk("cpu_hold", 32'(cpu_hold), 32'(exp_hold));
            chk("load_done", 32'(load_done), 32'(exp_done));
            chk("load_err", 32'(load_err), 32'(exp_err));
        end
    end

    initial begin
        int rv0;
        int err_cyc;

        // Reset state
        repeat (4) @(negedge clk);
        chk("rst_im_we", 32'(im_we), 32'd0);
        chk("rst_im_waddr", 32'(im_waddr), 32'd0);
        chk("rst_im_wdata", im_wdata, 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_load_err", 32'(load_err), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Two-word program with correct checksum
        fr = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        run_frame(-1);
        chk("t1_hold_during_load", 32'(hold_after_sync), 32'd1);
        chk("t1_write_count", 32'(obs_data.size()), 32'd2);
        if (obs_data.size() == 2) begin
            chk("t1_word0", obs_data[0], 32'h0000_0013);
            chk("t1_word1", obs_data[1], 32'h0010_0093);
            chk("t1_addr1", 32'(obs_addr[1]), 32'd1);
        end
        chk("t1_done", 32'(load_done), 32'd1);
        chk("t1_hold_released", 32'(cpu_hold), 32'd0);

        // Same program, bad checksum
        fr[10] = 8'hB7;
        run_frame(-1);
        chk("t2_write_count", 32'(obs_data.size()), 32'd2);
        chk("t2_err", 32'(load_err), 32'd1);
        chk("t2_hold", 32'(cpu_hold), 32'd1);

        // Length bounds
        fr = '{8'hA5, 8'h00};
        run_frame(-1);
        chk("len0_err", 32'(load_err), 32'd1);
        chk("len0_no_write", 32'(obs_data.size()), 32'd0);
        fr = '{8'hA5, 8'h81};
        run_frame(-1);
        chk("len129_err", 32'(load_err), 32'd1);
        chk("len129_no_write", 32'(obs_data.size()), 32'd0);
        good_frame(128, 32'hC0DE_1234);
        run_frame(-1);
        chk("len128_write_count", 32'(obs_data.size()), 32'd128);
        if (obs_addr.size() == 128) chk("len128_last_addr", 32'(obs_addr[127]), 32'd127);
        chk("len128_done", 32'(load_done), 32'd1);

        // Frame error on the third data byte, then recovery
        good_frame(1, 32'h1122_3344);
        run_frame(4);
        chk("ferr_err", 32'(load_err), 32'd1);
        chk("ferr_no_write", 32'(obs_data.size()), 32'd0);
        good_frame(1, 32'hDEAD_BEEF);
        run_frame(-1);
        chk("recover_done", 32'(load_done), 32'd1);
        chk("recover_err_cleared", 32'(load_err), 32'd0);

        // Glitch and stray byte in IDLE; flag compare keeps cpu_hold pinned at 0
        rv0 = rv_cnt;
        uart_rxd = 1'b0;
        repeat (5) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_no_rx_valid", 32'(rv_cnt), 32'(rv0));
        send_byte(8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        chk("stray_byte_received", 32'(rv_cnt), 32'(rv0 + 1));
        chk("stray_byte_hold", 32'(cpu_hold), 32'd0);

        // Reset mid-frame: word 0 stays written, outputs return to reset values
        flags_valid = 1'b0;
        fr = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00};
        model_frame(-1);
        send_frame(-1);
        chk("midrst_hold_before", 32'(cpu_hold), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_im_we", 32'(im_we), 32'd0);
        chk("midrst_im_waddr", 32'(im_waddr), 32'd0);
        chk("midrst_im_wdata", im_wdata, 32'd0);
        chk("midrst_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("midrst_load_done", 32'(load_done), 32'd0);
        chk("midrst_load_err", 32'(load_err), 32'd0);
        rst = 1'b0;
        exp_hold = 1'b0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        flags_valid = 1'b1;
        repeat (20) @(negedge clk);

        // Timeout: A5 01 AA BB then silence
        flags_valid = 1'b0;
        fr = '{8'hA5, 8'h01, 8'hAA, 8'hBB};
        model_frame(-1);
        send_frame(-1);
        err_cyc = -1;
        for (int i = 0; i < TMO + 200; i++) begin
            if (load_err) begin
                err_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("timeout_seen", 32'(err_cyc >= 0), 32'd1);
        if (err_cyc >= 0) chk("timeout_delay", 32'(err_cyc - last_rv), 32'(TMO));
        flags_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("timeout_hold", 32'(cpu_hold), 32'd1);
        chk("all_writes_seen", 32'(exp_addr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
